multi_clock_divider: RTL and testbench
======================================

# multi_clock_divider

Parametrised, runtime-programmable clock divider with CH_COUNT independent channels. Each channel divides the system clock by a programmable half-period count. It produces a 50 %-duty divided clock and a single-cycle tick strobe at every half-period boundary. The block replaces fixed-ratio dividers in the FND/stopwatch datapath: one instance supplies the digit-scan tick, the stopwatch time base and slower blink rates, all from one clock domain.

## Interface
- CH_COUNT, 4, number of independent channels (1..16)
- CNT_W, 27, width of each divisor and counter
- DEFAULT_DIV, 50_000, half-period count loaded into every channel at reset

- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- i_en  input  CH_COUNT  per-channel enable, level
- i_load  input  CH_COUNT  per-channel single-cycle strobe: capture divisor into shadow register
- i_div  input  CH_COUNT*CNT_W  packed divisors; channel k uses bits [k*CNT_W +: CNT_W]
- i_sync  input  1  single-cycle strobe: phase-align all channels
- o_clk  output  CH_COUNT  divided clock per channel (registered)
- o_tick  output  CH_COUNT  one-cycle strobe per channel at each half-period boundary (registered)
- o_pending  output  CH_COUNT  shadow divisor loaded but not yet applied

## Operation
- Per-channel state: counter cnt (CNT_W), active divisor act, shadow divisor shd, pending flag, o_clk and o_tick registers.
- Effective divisor N = act, with act = 0 treated as 1. The output period is 2N clk cycles and the tick rate is one per N cycles.
- Enabled channel, per edge:
  - If cnt == N-1: cnt <= 0, o_clk toggles, o_tick <= 1. If pending, act <= shd and pending clears at the same edge. The new divisor governs the next half-period.
  - Otherwise: cnt <= cnt+1, o_tick <= 0.
- Disabled channel (i_en[k]=0): cnt held at 0, o_clk <= 0, o_tick <= 0. A pending shd is applied immediately (act <= shd, pending clears).
- i_load[k]: shd <= i_div slice and pending <= 1 at that edge. A second load before application overwrites shd; the last value wins.
- i_sync applies to all channels, enabled or not, and has priority over the wrap and count logic:
  - cnt <= 0, o_clk <= 0, o_tick <= 0.
  - A pending shd is applied immediately.
- i_load and i_sync at the same edge: shd captures i_div and is also applied at that edge. act = new value, pending = 0.
- i_load at the same edge as a wrap: the wrap applies the old shd if one was pending. The new value becomes shd with pending = 1.
- Counter compare is an equality test on CNT_W bits. Counters never exceed N-1, even after act shrinks, because a new act only takes effect when cnt = 0.

## Timing
- Reset (reset = 0, asynchronous):
  - o_clk = 0, o_tick = 0, o_pending = 0.
  - cnt = 0, act = shd = DEFAULT_DIV for all channels.
- Reset release is not synchronised internally. The first active edge is the first rising clk with reset = 1.
- First enabled edge E1 (i_en[k] = 1 sampled):
  - cnt goes 1..N-1 over E1..E(N-1).
  - At EN, cnt wraps and o_clk rises. o_tick is 1 for exactly the cycle after EN.
- Steady state:
  - o_clk high N cycles, low N cycles.
  - o_tick high 1 cycle every N cycles, coincident with each o_clk edge (both registered at the same clk edge).
- N = 1: o_tick is continuously 1 while enabled, and o_clk = clk/2.
- Reset asserted mid-period forces all outputs to reset values immediately, without waiting for a clock. Pending loads are discarded.
- o_pending[k] rises the cycle after an i_load edge and falls the cycle after the applying edge.

## Test plan
- Reset and defaults: hold reset = 0 with random inputs -> o_clk = 0, o_tick = 0, o_pending = 0. Release with i_en = 1 and DEFAULT_DIV = 4 (override) -> first o_clk rise at the 4th enabled edge, period 8.
- Channel 0 with N = 3, channel 1 with N = 5, both enabled -> o_clk[0] period 6, 3 high/3 low; o_tick[0] every 3 cycles; o_clk[1] period 10. Channels stay independent for 60 cycles.
- N = 0 loaded on a disabled channel, then enable -> behaves as N = 1: o_tick stays 1, o_clk toggles every cycle.
- Load mid-period: N = 10, i_load with 2 at cnt = 4 -> o_pending = 1. The current half-period still lasts 10 cycles, then half-periods of 2. o_pending clears at the wrap.
- Simultaneous events:
  - i_load + i_sync in the same cycle -> outputs 0, new divisor active immediately, o_pending = 0.
  - i_load at the wrap edge -> old pending value applied, new value pending.
- Asynchronous reset mid-period (cnt = 7 of N = 10, o_clk = 1, pending load) -> outputs drop before the next clk edge. After release, defaults apply and the pending load is gone.

Source files
------------

// File: rtl/multi_clock_divider.sv
// Programmable multi-channel clock divider: per-channel half-period counter with
// shadowed divisor reload, 50% duty output clock and half-period tick strobe.
module multi_clock_divider #(
   parameter int CH_COUNT    = 4,
   parameter int CNT_W       = 27,
   parameter int DEFAULT_DIV = 50_000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CH_COUNT-1:0]       i_en,
   input  logic [CH_COUNT-1:0]       i_load,
   input  logic [CH_COUNT*CNT_W-1:0] i_div,
   input  logic                      i_sync,
   output logic [CH_COUNT-1:0]       o_clk,
   output logic [CH_COUNT-1:0]       o_tick,
   output logic [CH_COUNT-1:0]       o_pending
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0]    cnt_q [CH_COUNT];
   logic [CNT_W-1:0]    cnt_d [CH_COUNT];
   logic [CNT_W-1:0]    act_q [CH_COUNT];
   logic [CNT_W-1:0]    act_d [CH_COUNT];
   logic [CNT_W-1:0]    shd_q [CH_COUNT];
   logic [CNT_W-1:0]    shd_d [CH_COUNT];
   logic [CH_COUNT-1:0] pend_q, pend_d;
   logic [CH_COUNT-1:0] div_clk_q, div_clk_d;
   logic [CH_COUNT-1:0] tick_q, tick_d;

   // A zero divisor behaves as one so the wrap compare can never be skipped.
   function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] a);
      return (a == '0) ? ONE : a;
   endfunction

   always_comb begin
      pend_d    = pend_q;
      div_clk_d = div_clk_q;
      tick_d    = tick_q;
      for (int k = 0; k < CH_COUNT; k++) begin
         cnt_d[k] = cnt_q[k];
         act_d[k] = act_q[k];
         shd_d[k] = shd_q[k];
         if (i_sync) begin
            cnt_d[k]     = '0;
            div_clk_d[k] = 1'b0;
            tick_d[k]    = 1'b0;
            if (i_load[k]) begin
               shd_d[k]  = i_div[k*CNT_W +: CNT_W];
               act_d[k]  = i_div[k*CNT_W +: CNT_W];
               pend_d[k] = 1'b0;
            end else if (pend_q[k]) begin
               act_d[k]  = shd_q[k];
               pend_d[k] = 1'b0;
            end
         end else begin
            if (!i_en[k]) begin
               cnt_d[k]     = '0;
               div_clk_d[k] = 1'b0;
               tick_d[k]    = 1'b0;
               if (pend_q[k]) begin
                  act_d[k]  = shd_q[k];
                  pend_d[k] = 1'b0;
               end
            end else if (cnt_q[k] == eff_div(act_q[k]) - ONE) begin
               cnt_d[k]     = '0;
               div_clk_d[k] = ~div_clk_q[k];
               tick_d[k]    = 1'b1;
               if (pend_q[k]) begin
                  act_d[k]  = shd_q[k];
                  pend_d[k] = 1'b0;
               end
            end else begin
               cnt_d[k]  = cnt_q[k] + ONE;
               tick_d[k] = 1'b0;
            end
            // A load on the same edge as an apply becomes the next pending value.
            if (i_load[k]) begin
               shd_d[k]  = i_div[k*CNT_W +: CNT_W];
               pend_d[k] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < CH_COUNT; k++) begin
            cnt_q[k] <= '0;
            act_q[k] <= DEF_DIV;
            shd_q[k] <= DEF_DIV;
         end
         pend_q    <= '0;
         div_clk_q <= '0;
         tick_q    <= '0;
      end else begin
         for (int k = 0; k < CH_COUNT; k++) begin
            cnt_q[k] <= cnt_d[k];
            act_q[k] <= act_d[k];
            shd_q[k] <= shd_d[k];
         end
         pend_q    <= pend_d;
         div_clk_q <= div_clk_d;
         tick_q    <= tick_d;
      end
   end

   assign o_clk     = div_clk_q;
   assign o_tick    = tick_q;
   assign o_pending = pend_q;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: defaults, independent channels, N=0,
// shadow reload timing, simultaneous sync/load/wrap and asynchronous reset.
module tb_multi_clock_divider;

   localparam int CH_COUNT = 4;
   localparam int CNT_W    = 8;
   localparam int DW       = CH_COUNT * CNT_W;

   logic                clk = 1'b0;
   logic                reset;
   logic [CH_COUNT-1:0] i_en;
   logic [CH_COUNT-1:0] i_load;
   logic [DW-1:0]       i_div;
   logic                i_sync;
   logic [CH_COUNT-1:0] o_clk;
   logic [CH_COUNT-1:0] o_tick;
   logic [CH_COUNT-1:0] o_pending;

   int tests_run    = 0;
   int tests_failed = 0;

   multi_clock_divider #(
      .CH_COUNT(CH_COUNT),
      .CNT_W(CNT_W),
      .DEFAULT_DIV(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .i_en(i_en),
      .i_load(i_load),
      .i_div(i_div),
      .i_sync(i_sync),
      .o_clk(o_clk),
      .o_tick(o_tick),
      .o_pending(o_pending)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Channel enabled since edge E1 with divisor n: after edge Ek the output has
   // toggled floor(k/n) times and the tick fires on multiples of n.
   task automatic chk_phase(input string tag, input int ch, input int k, input int n);
      check($sformatf("%s_clk_ch%0d_k%0d", tag, ch, k), 32'(o_clk[ch]), 32'((k / n) % 2));
      check($sformatf("%s_tick_ch%0d_k%0d", tag, ch, k), 32'(o_tick[ch]), 32'(k % n == 0));
   endtask

   task automatic set_div(input int ch, input logic [CNT_W-1:0] val);
      i_div[ch*CNT_W +: CNT_W] = val;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset  = 1'b0;
      i_en   = '0;
      i_load = '0;
      i_div  = '0;
      i_sync = 1'b0;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         i_en   = CH_COUNT'($urandom);
         i_load = CH_COUNT'($urandom);
         i_sync = 1'($urandom);
         i_div  = DW'($urandom);
         step();
         check("rst_clk", 32'(o_clk), 32'h0);
         check("rst_tick", 32'(o_tick), 32'h0);
         check("rst_pend", 32'(o_pending), 32'h0);
      end

      // Release with all channels enabled at the default divisor of 4
      i_en   = '1;
      i_load = '0;
      i_sync = 1'b0;
      i_div  = '0;
      #2 reset = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         for (int ch = 0; ch < CH_COUNT; ch++) chk_phase("def", ch, k, 4);
      end
      check("def_pend", 32'(o_pending), 32'h0);

      // Channels 0 and 1 at N=3 and N=5
      i_en = '0;
      set_div(0, 8'd3);
      set_div(1, 8'd5);
      i_load = 4'b0011;
      step();
      i_load = '0;
      check("ld01_pend_set", 32'(o_pending), 32'h3);
      step();
      check("ld01_pend_clr", 32'(o_pending), 32'h0);
      i_en = 4'b0011;
      for (int k = 1; k <= 60; k++) begin
         step();
         chk_phase("n3", 0, k, 3);
         chk_phase("n5", 1, k, 5);
         check($sformatf("idle_ch2_k%0d", k), 32'(o_clk[2]), 32'h0);
      end

      // N=0 on channel 2 behaves as N=1
      i_en = '0;
      set_div(2, 8'd0);
      i_load = 4'b0100;
      step();
      i_load = '0;
      step();
      i_en = 4'b0100;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_phase("n0", 2, k, 1);
      end
      check("n0_pend", 32'(o_pending), 32'h0);

      // Mid-period reload on channel 3: N=10, load 2 while cnt=4
      i_en = '0;
      set_div(3, 8'd10);
      i_load = 4'b1000;
      step();
      i_load = '0;
      step();
      i_en = 4'b1000;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk_phase("mid", 3, k, 10);
      end
      set_div(3, 8'd2);
      i_load = 4'b1000;
      step();
      i_load = '0;
      check("mid_pend_set", 32'(o_pending[3]), 32'h1);
      chk_phase("mid", 3, 5, 10);
      for (int k = 6; k <= 10; k++) begin
         step();
         chk_phase("mid", 3, k, 10);
      end
      check("mid_pend_clr", 32'(o_pending[3]), 32'h0);
      for (int j = 1; j <= 8; j++) begin
         step();
         check($sformatf("mid_n2_clk_j%0d", j), 32'(o_clk[3]), 32'(1 ^ ((j / 2) % 2)));
         check($sformatf("mid_n2_tick_j%0d", j), 32'(o_tick[3]), 32'(j % 2 == 0));
      end

      // Load together with sync: outputs cleared, new divisor 6 active at once
      set_div(3, 8'd6);
      i_load = 4'b1000;
      i_sync = 1'b1;
      step();
      i_load = '0;
      i_sync = 1'b0;
      check("sync_clk", 32'(o_clk), 32'h0);
      check("sync_tick", 32'(o_tick), 32'h0);
      check("sync_pend", 32'(o_pending), 32'h0);
      for (int k = 1; k <= 12; k++) begin
         step();
         chk_phase("sync6", 3, k, 6);
      end

      // Load 3 early, then load 2 exactly on the wrap edge (k=18)
      set_div(3, 8'd3);
      i_load = 4'b1000;
      step();
      i_load = '0;
      check("wrap_pend_a", 32'(o_pending[3]), 32'h1);
      chk_phase("wrap6", 3, 13, 6);
      for (int k = 14; k <= 17; k++) begin
         step();
         chk_phase("wrap6", 3, k, 6);
      end
      set_div(3, 8'd2);
      i_load = 4'b1000;
      step();
      i_load = '0;
      chk_phase("wrap6", 3, 18, 6);
      check("wrap_pend_b", 32'(o_pending[3]), 32'h1);
      step();
      check("w19_clk", 32'(o_clk[3]), 32'h1);
      check("w19_tick", 32'(o_tick[3]), 32'h0);
      check("w19_pend", 32'(o_pending[3]), 32'h1);
      step();
      check("w20_clk", 32'(o_clk[3]), 32'h1);
      check("w20_tick", 32'(o_tick[3]), 32'h0);
      step();
      check("w21_clk", 32'(o_clk[3]), 32'h0);
      check("w21_tick", 32'(o_tick[3]), 32'h1);
      check("w21_pend", 32'(o_pending[3]), 32'h0);
      step();
      check("w22_clk", 32'(o_clk[3]), 32'h0);
      check("w22_tick", 32'(o_tick[3]), 32'h0);
      step();
      check("w23_clk", 32'(o_clk[3]), 32'h1);
      check("w23_tick", 32'(o_tick[3]), 32'h1);

      // Asynchronous reset at cnt=7 of N=10 with o_clk high and a load pending
      i_en = '0;
      i_sync = 1'b1;
      step();
      i_sync = 1'b0;
      set_div(0, 8'd10);
      i_load = 4'b0001;
      step();
      i_load = '0;
      step();
      i_en = 4'b0001;
      for (int k = 1; k <= 10; k++) begin
         step();
         chk_phase("ar10", 0, k, 10);
      end
      set_div(0, 8'd5);
      i_load = 4'b0001;
      step();
      i_load = '0;
      for (int k = 12; k <= 17; k++) step();
      check("ar_pre_clk", 32'(o_clk[0]), 32'h1);
      check("ar_pre_pend", 32'(o_pending[0]), 32'h1);
      #2 reset = 1'b0;
      #1;
      check("ar_clk", 32'(o_clk), 32'h0);
      check("ar_tick", 32'(o_tick), 32'h0);
      check("ar_pend", 32'(o_pending), 32'h0);
      #1 reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_phase("ar_def", 0, k, 4);
      end
      check("ar_def_pend", 32'(o_pending), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
